// File: rtl/led_event_pkg.sv
// Shared types and constants for the LED sweep event block.
package led_event_pkg;

  typedef enum logic [1:0] {
    ONESHOT = 2'd0,
    LOOP    = 2'd1,
    BOUNCE  = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // The unused encoding 3 behaves as LOOP.
  function automatic mode_t decode_mode(input logic [1:0] raw);
    mode_t m;
    case (raw)
      2'd0:    m = ONESHOT;
      2'd2:    m = BOUNCE;
      default: m = LOOP;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Divides the clock into sweep steps: tick fires on the last count while enabled.
module step_prescaler #(
  parameter int unsigned STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DivW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(STEP_DIV - 1);

  logic [DivW-1:0] div_q, div_d;

  assign tick = en && (div_q == DivLast);

  always_comb begin
    div_d = div_q;
    if (clr || tick) begin
      div_d = '0;
    end else if (en) begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/led_sweep_event.sv
// Button-driven LED sweep: steps a lit position across the LEDs while the button is held.
module led_sweep_event
  import led_event_pkg::*;
#(
  parameter int unsigned N_LEDS   = 8,
  parameter int unsigned STEP_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              button_inp,
  input  logic [1:0]        mode,
  input  logic              fill,
  output logic [N_LEDS-1:0] led,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PosW = $clog2(N_LEDS);
  localparam logic [PosW-1:0] PosLast = PosW'(N_LEDS - 1);

  state_t          state_q, state_d;
  mode_t           mode_q, mode_d;
  logic            btn_q;
  logic [PosW-1:0] pos_q, pos_d;
  logic            dir_q, dir_d;
  logic            fill_q, fill_d;
  logic            done_q, done_d;
  logic            step_en, step_tick;
  logic [N_LEDS-1:0] pattern;

  // Prescaler only counts while actively sweeping; a release on a step edge suppresses the step.
  assign step_en = (state_q == RUN) && btn_q;

  step_prescaler #(
    .STEP_DIV(STEP_DIV)
  ) u_step_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (step_en),
    .clr (!step_en),
    .tick(step_tick)
  );

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        pos_d = '0;
        dir_d = DIR_UP;
        if (btn_q) begin
          state_d = RUN;
          mode_d  = decode_mode(mode);
          fill_d  = fill;
        end
      end
      RUN: begin
        if (!btn_q) begin
          state_d = IDLE;
          pos_d   = '0;
          dir_d   = DIR_UP;
        end else if (step_tick) begin
          unique case (mode_q)
            ONESHOT: begin
              if (pos_q == PosLast) begin
                state_d = HOLD;
                done_d  = 1'b1;
              end else begin
                pos_d = pos_q + 1'b1;
              end
            end
            BOUNCE: begin
              if (dir_q == DIR_UP) begin
                pos_d = pos_q + 1'b1;
                if (pos_q == PosLast - 1'b1) dir_d = DIR_DOWN;
              end else begin
                pos_d = pos_q - 1'b1;
                if (pos_q == PosW'(1)) begin
                  dir_d  = DIR_UP;
                  done_d = 1'b1;
                end
              end
            end
            default: begin
              if (pos_q == PosLast) begin
                pos_d  = '0;
                done_d = 1'b1;
              end else begin
                pos_d = pos_q + 1'b1;
              end
            end
          endcase
        end
      end
      HOLD: begin
        if (!btn_q) begin
          state_d = IDLE;
          pos_d   = '0;
          dir_d   = DIR_UP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      btn_q   <= 1'b0;
      pos_q   <= '0;
      dir_q   <= DIR_UP;
      mode_q  <= ONESHOT;
      fill_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= button_inp;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    pattern = '0;
    if (state_q != IDLE) begin
      for (int unsigned i = 0; i < N_LEDS; i++) begin
        pattern[i] = fill_q ? (PosW'(i) <= pos_q) : (PosW'(i) == pos_q);
      end
    end
  end

  // Gating on the raw input blanks the LEDs in the very cycle the button is released.
  assign led  = pattern & {N_LEDS{button_inp}};
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_led_sweep_event.sv
// Directed bench: table-driven vectors on a STEP_DIV=1 instance plus timed sequences at STEP_DIV=4.
module tb_led_sweep_event;

  logic       clk = 1'b0;
  logic       rst;
  logic       button_inp;
  logic [1:0] mode;
  logic       fill;
  logic [7:0] led4, led1;
  logic       busy4, busy1, done4, done1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_sweep_event #(
    .N_LEDS  (8),
    .STEP_DIV(4)
  ) dut4 (
    .clk       (clk),
    .rst       (rst),
    .button_inp(button_inp),
    .mode      (mode),
    .fill      (fill),
    .led       (led4),
    .busy      (busy4),
    .done      (done4)
  );

  led_sweep_event #(
    .N_LEDS  (8),
    .STEP_DIV(1)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .button_inp(button_inp),
    .mode      (mode),
    .fill      (fill),
    .led       (led1),
    .busy      (busy1),
    .done      (done1)
  );

  typedef struct {
    logic       btn;
    logic [1:0] mode;
    logic       fill;
    logic [7:0] led;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic b, input logic [1:0] m, input logic f,
                              input logic [7:0] l, input logic bz, input logic d);
    vec_t v;
    v.btn  = b;
    v.mode = m;
    v.fill = f;
    v.led  = l;
    v.busy = bz;
    v.done = d;
    vecs.push_back(v);
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_led;
    logic       exp_done;
    int         pos;

    // LOOP fill (STEP_DIV=1): start latency, full bar, wrap with done, release.
    add(1'b1, 2'd1, 1'b1, 8'h00, 1'b0, 1'b0);
    add(1'b1, 2'd1, 1'b1, 8'h01, 1'b1, 1'b0);
    add(1'b1, 2'd1, 1'b1, 8'h03, 1'b1, 1'b0);
    add(1'b1, 2'd1, 1'b1, 8'h07, 1'b1, 1'b0);
    add(1'b1, 2'd1, 1'b1, 8'h0F, 1'b1, 1'b0);
    add(1'b1, 2'd1, 1'b1, 8'h1F, 1'b1, 1'b0);
    add(1'b1, 2'd1, 1'b1, 8'h3F, 1'b1, 1'b0);
    add(1'b1, 2'd1, 1'b1, 8'h7F, 1'b1, 1'b0);
    add(1'b1, 2'd1, 1'b1, 8'hFF, 1'b1, 1'b0);
    add(1'b1, 2'd1, 1'b1, 8'h01, 1'b1, 1'b1);
    add(1'b1, 2'd1, 1'b1, 8'h03, 1'b1, 1'b0);
    add(1'b0, 2'd1, 1'b1, 8'h00, 1'b1, 1'b0);
    add(1'b0, 2'd1, 1'b1, 8'h00, 1'b0, 1'b0);
    // ONESHOT dot: done on the step taken at the last LED, then HOLD.
    add(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b1, 2'd0, 1'b0, 8'h01, 1'b1, 1'b0);
    add(1'b1, 2'd0, 1'b0, 8'h02, 1'b1, 1'b0);
    add(1'b1, 2'd0, 1'b0, 8'h04, 1'b1, 1'b0);
    add(1'b1, 2'd0, 1'b0, 8'h08, 1'b1, 1'b0);
    add(1'b1, 2'd0, 1'b0, 8'h10, 1'b1, 1'b0);
    add(1'b1, 2'd0, 1'b0, 8'h20, 1'b1, 1'b0);
    add(1'b1, 2'd0, 1'b0, 8'h40, 1'b1, 1'b0);
    add(1'b1, 2'd0, 1'b0, 8'h80, 1'b1, 1'b0);
    add(1'b1, 2'd0, 1'b0, 8'h80, 1'b1, 1'b1);
    add(1'b1, 2'd0, 1'b0, 8'h80, 1'b1, 1'b0);
    add(1'b1, 2'd0, 1'b0, 8'h80, 1'b1, 1'b0);
    add(1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0);
    add(1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    // BOUNCE dot: endpoints once each, done only on return to LED 0, period 14.
    add(1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b1, 2'd2, 1'b0, 8'h01, 1'b1, 1'b0);
    add(1'b1, 2'd2, 1'b0, 8'h02, 1'b1, 1'b0);
    add(1'b1, 2'd2, 1'b0, 8'h04, 1'b1, 1'b0);
    add(1'b1, 2'd2, 1'b0, 8'h08, 1'b1, 1'b0);
    add(1'b1, 2'd2, 1'b0, 8'h10, 1'b1, 1'b0);
    add(1'b1, 2'd2, 1'b0, 8'h20, 1'b1, 1'b0);
    add(1'b1, 2'd2, 1'b0, 8'h40, 1'b1, 1'b0);
    add(1'b1, 2'd2, 1'b0, 8'h80, 1'b1, 1'b0);
    add(1'b1, 2'd2, 1'b0, 8'h40, 1'b1, 1'b0);
    add(1'b1, 2'd2, 1'b0, 8'h20, 1'b1, 1'b0);
    add(1'b1, 2'd2, 1'b0, 8'h10, 1'b1, 1'b0);
    add(1'b1, 2'd2, 1'b0, 8'h08, 1'b1, 1'b0);
    add(1'b1, 2'd2, 1'b0, 8'h04, 1'b1, 1'b0);
    add(1'b1, 2'd2, 1'b0, 8'h02, 1'b1, 1'b0);
    add(1'b1, 2'd2, 1'b0, 8'h01, 1'b1, 1'b1);
    add(1'b1, 2'd2, 1'b0, 8'h02, 1'b1, 1'b0);
    add(1'b0, 2'd2, 1'b0, 8'h00, 1'b1, 1'b0);
    add(1'b0, 2'd2, 1'b0, 8'h00, 1'b0, 1'b0);
    // Mode 3 behaves as LOOP: wraps to LED 0 instead of bouncing.
    add(1'b1, 2'd3, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b1, 2'd3, 1'b0, 8'h01, 1'b1, 1'b0);
    add(1'b1, 2'd3, 1'b0, 8'h02, 1'b1, 1'b0);
    add(1'b1, 2'd3, 1'b0, 8'h04, 1'b1, 1'b0);
    add(1'b1, 2'd3, 1'b0, 8'h08, 1'b1, 1'b0);
    add(1'b1, 2'd3, 1'b0, 8'h10, 1'b1, 1'b0);
    add(1'b1, 2'd3, 1'b0, 8'h20, 1'b1, 1'b0);
    add(1'b1, 2'd3, 1'b0, 8'h40, 1'b1, 1'b0);
    add(1'b1, 2'd3, 1'b0, 8'h80, 1'b1, 1'b0);
    add(1'b1, 2'd3, 1'b0, 8'h01, 1'b1, 1'b1);
    add(1'b0, 2'd3, 1'b0, 8'h00, 1'b1, 1'b0);
    add(1'b0, 2'd3, 1'b0, 8'h00, 1'b0, 1'b0);

    rst        = 1'b1;
    button_inp = 1'b0;
    mode       = 2'd0;
    fill       = 1'b0;
    repeat (2) edge1();
    check8("reset led4", led4, 8'h00);
    check1("reset busy4", busy4, 1'b0);
    check1("reset done4", done4, 1'b0);
    check8("reset led1", led1, 8'h00);
    check1("reset busy1", busy1, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      button_inp = vecs[i].btn;
      mode       = vecs[i].mode;
      fill       = vecs[i].fill;
      edge1();
      check8($sformatf("vec%0d led", i), led1, vecs[i].led);
      check1($sformatf("vec%0d busy", i), busy1, vecs[i].busy);
      check1($sformatf("vec%0d done", i), done1, vecs[i].done);
    end

    // STEP_DIV=4 LOOP fill: steps every 4 edges from cycle 2, wrap with done at 34.
    mode       = 2'd1;
    fill       = 1'b1;
    button_inp = 1'b1;
    for (int c = 1; c <= 55; c++) begin
      edge1();
      if (c == 1) begin
        check8("loop4 c1 led", led4, 8'h00);
        check1("loop4 c1 busy", busy4, 1'b0);
      end else begin
        pos      = ((c - 2) / 4) % 8;
        exp_led  = 8'((2 << pos) - 1);
        exp_done = (c > 2) && ((c - 2) % 4 == 0) && (pos == 0);
        check8($sformatf("loop4 c%0d led", c), led4, exp_led);
        check1($sformatf("loop4 c%0d busy", c), busy4, 1'b1);
        check1($sformatf("loop4 c%0d done", c), done4, exp_done);
      end
    end
    // Release at pos 5: blank immediately, busy drops two edges later.
    button_inp = 1'b0;
    #1;
    check8("release same-cycle led", led4, 8'h00);
    check1("release same-cycle busy", busy4, 1'b1);
    edge1();
    check1("release +1 busy", busy4, 1'b1);
    check1("release +1 done", done4, 1'b0);
    edge1();
    check1("release +2 busy", busy4, 1'b0);

    // Re-press as LOOP dot; mode/fill changes mid-sweep must be ignored.
    mode       = 2'd1;
    fill       = 1'b0;
    button_inp = 1'b1;
    for (int c = 1; c <= 38; c++) begin
      edge1();
      if (c == 1) begin
        check8("dot4 c1 led", led4, 8'h00);
      end else begin
        pos      = ((c - 2) / 4) % 8;
        exp_led  = 8'(1 << pos);
        exp_done = (c > 2) && ((c - 2) % 4 == 0) && (pos == 0);
        check8($sformatf("dot4 c%0d led", c), led4, exp_led);
        check1($sformatf("dot4 c%0d done", c), done4, exp_done);
      end
      if (c == 3) begin
        mode = 2'd2;
        fill = 1'b1;
      end
    end
    button_inp = 1'b0;
    repeat (2) edge1();
    check1("dot4 idle busy", busy4, 1'b0);

    // Re-press picks up the new BOUNCE/fill settings.
    button_inp = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      edge1();
      if (c == 2) check8("bnc4 c2 led", led4, 8'h01);
      if (c == 6) check8("bnc4 c6 led", led4, 8'h03);
      if (c == 30) check8("bnc4 c30 led", led4, 8'hFF);
      if (c == 34) check8("bnc4 c34 led", led4, 8'h7F);
    end
    button_inp = 1'b0;
    repeat (2) edge1();

    // Async reset mid-sweep at 8'h1F, then a held button restarts from LED 0.
    mode       = 2'd1;
    fill       = 1'b1;
    button_inp = 1'b1;
    repeat (18) edge1();
    check8("rst pre led", led4, 8'h1F);
    #2;
    rst = 1'b1;
    #1;
    check8("rst async led", led4, 8'h00);
    check1("rst async busy", busy4, 1'b0);
    check1("rst async done", done4, 1'b0);
    edge1();
    rst = 1'b0;
    edge1();
    check8("rst +1 led", led4, 8'h00);
    check1("rst +1 busy", busy4, 1'b0);
    edge1();
    check8("rst +2 led", led4, 8'h01);
    check1("rst +2 busy", busy4, 1'b1);
    check1("rst +2 done", done4, 1'b0);
    repeat (4) edge1();
    check8("rst +6 led", led4, 8'h03);
    button_inp = 1'b0;
    repeat (2) edge1();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
